// File: rtl/id_ex_stage_if.sv
// ID->EX pipeline bus: decoded ID fields and pipeline control in, registered EX fields and stall out.
interface id_ex_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
);
  logic [2:0]        OpCode;
  logic              RegWrite;
  logic              RegDst;
  logic              ALUSrc;
  logic              Branch;
  logic              MemWrite;
  logic              MemRead;
  logic              MemtoReg;
  logic [1:0]        ALUOp;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [DATA_W-1:0] SignExtImm;
  logic [DATA_W-1:0] PCPlus;
  logic [REG_W-1:0]  Rs;
  logic [REG_W-1:0]  Rt;
  logic [REG_W-1:0]  Rd;
  logic              Flush;
  logic              Hold;

  logic              ex_RegWrite;
  logic              ex_RegDst;
  logic              ex_ALUSrc;
  logic              ex_Branch;
  logic              ex_MemWrite;
  logic              ex_MemRead;
  logic              ex_MemtoReg;
  logic [1:0]        ex_ALUOp;
  logic [DATA_W-1:0] ex_ReadData1;
  logic [DATA_W-1:0] ex_ReadData2;
  logic [DATA_W-1:0] ex_SignExtImm;
  logic [DATA_W-1:0] ex_PCPlus;
  logic [REG_W-1:0]  ex_Rs;
  logic [REG_W-1:0]  ex_Rt;
  logic [REG_W-1:0]  ex_Rd;
  logic              ex_Valid;
  logic              Stall;
  logic [15:0]       BubbleCount;

  modport slave (
    input  OpCode, RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemRead, MemtoReg, ALUOp,
    input  ReadData1, ReadData2, SignExtImm, PCPlus, Rs, Rt, Rd, Flush, Hold,
    output ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_Branch, ex_MemWrite, ex_MemRead, ex_MemtoReg,
    output ex_ALUOp, ex_ReadData1, ex_ReadData2, ex_SignExtImm, ex_PCPlus,
    output ex_Rs, ex_Rt, ex_Rd, ex_Valid, Stall, BubbleCount
  );

  modport master (
    output OpCode, RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemRead, MemtoReg, ALUOp,
    output ReadData1, ReadData2, SignExtImm, PCPlus, Rs, Rt, Rd, Flush, Hold,
    input  ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_Branch, ex_MemWrite, ex_MemRead, ex_MemtoReg,
    input  ex_ALUOp, ex_ReadData1, ex_ReadData2, ex_SignExtImm, ex_PCPlus,
    input  ex_Rs, ex_Rt, ex_Rd, ex_Valid, Stall, BubbleCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush/hold control and a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input logic          clock,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  // Control packing: {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemRead, MemtoReg, ALUOp[1:0]}
  logic [8:0]        w_id_ctrl;
  logic              w_rs_use;
  logic              w_rt_use;
  logic              w_stall;
  logic              w_load_data;

  logic [8:0]        r_ctrl;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_rd;
  logic              r_valid;
  logic [15:0]       r_bcnt;

  assign w_id_ctrl = {bus.RegWrite, bus.RegDst, bus.ALUSrc, bus.Branch,
                      bus.MemWrite, bus.MemRead, bus.MemtoReg, bus.ALUOp};

  // Which register fields the ID opcode actually reads
  always_comb begin
    w_rs_use = 1'b0;
    w_rt_use = 1'b0;
    case (bus.OpCode)
      3'd0, 3'd2, 3'd6: begin
        w_rs_use = 1'b1;
        w_rt_use = 1'b1;
      end
      3'd3, 3'd5: begin
        w_rs_use = 1'b1;
        w_rt_use = 1'b0;
      end
      default: begin
        w_rs_use = 1'b0;
        w_rt_use = 1'b0;
      end
    endcase
  end

  // ex_Valid=0 after the bubble breaks the condition, so no extra stall state is needed
  assign w_stall = r_valid & r_ctrl[3]
                 & ((w_rs_use & (bus.Rs == r_rt)) | (w_rt_use & (bus.Rt == r_rt)))
                 & ~bus.Flush & ~bus.Hold;

  assign w_load_data = bus.Flush | ~bus.Hold;

  // Control, valid and bubble counter with Flush > Hold > Stall > Load priority
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ctrl  <= 9'd0;
      r_valid <= 1'b0;
      r_bcnt  <= 16'd0;
    end else if (bus.Flush) begin
      r_ctrl  <= 9'd0;
      r_valid <= 1'b0;
    end else if (bus.Hold) begin
      r_ctrl  <= r_ctrl;
      r_valid <= r_valid;
    end else if (w_stall) begin
      r_ctrl  <= 9'd0;
      r_valid <= 1'b0;
      if (r_bcnt != 16'hFFFF) begin
        r_bcnt <= r_bcnt + 16'd1;
      end
    end else begin
      r_ctrl  <= w_id_ctrl;
      r_valid <= 1'b1;
    end
  end

  // Datapath fields load on every non-held edge; their value is irrelevant under a bubble
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd1 <= '0;
      r_rd2 <= '0;
      r_imm <= '0;
      r_pc  <= '0;
      r_rs  <= '0;
      r_rt  <= '0;
      r_rd  <= '0;
    end else if (w_load_data) begin
      r_rd1 <= bus.ReadData1;
      r_rd2 <= bus.ReadData2;
      r_imm <= bus.SignExtImm;
      r_pc  <= bus.PCPlus;
      r_rs  <= bus.Rs;
      r_rt  <= bus.Rt;
      r_rd  <= bus.Rd;
    end
  end

  assign {bus.ex_RegWrite, bus.ex_RegDst, bus.ex_ALUSrc, bus.ex_Branch,
          bus.ex_MemWrite, bus.ex_MemRead, bus.ex_MemtoReg, bus.ex_ALUOp} = r_ctrl;
  assign bus.ex_ReadData1  = r_rd1;
  assign bus.ex_ReadData2  = r_rd2;
  assign bus.ex_SignExtImm = r_imm;
  assign bus.ex_PCPlus     = r_pc;
  assign bus.ex_Rs         = r_rs;
  assign bus.ex_Rt         = r_rt;
  assign bus.ex_Rd         = r_rd;
  assign bus.ex_Valid      = r_valid;
  assign bus.Stall         = w_stall;
  assign bus.BubbleCount   = r_bcnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a behavioural stage model pushes expected EX state
// to a queue at each drive, and the queue is popped and checked after the edge.
module tb_id_ex_stage;
  localparam int DW = 16;
  localparam int RW = 3;

  localparam logic [8:0] C_ADDI  = 9'b1_0_1_0_0_0_0_00;
  localparam logic [8:0] C_LOAD  = 9'b1_0_1_0_0_1_1_00;
  localparam logic [8:0] C_RTYPE = 9'b1_1_0_0_0_0_0_10;
  localparam logic [8:0] C_BR    = 9'b0_0_0_1_0_0_0_01;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  id_ex_stage_if #(.DATA_W(DW), .REG_W(RW)) bus ();
  id_ex_stage #(.DATA_W(DW), .REG_W(RW)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [15:0] rd1, rd2, imm, pc;
    logic [2:0]  rs, rt, rd;
    logic        valid;
    logic [15:0] bcnt;
    logic        dk;
  } exp_t;

  exp_t m;
  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [2:0] op, input logic [8:0] c, input logic [2:0] rs,
                        input logic [2:0] rt, input logic [2:0] rd, input logic [15:0] imm);
    bus.OpCode = op;
    {bus.RegWrite, bus.RegDst, bus.ALUSrc, bus.Branch,
     bus.MemWrite, bus.MemRead, bus.MemtoReg, bus.ALUOp} = c;
    bus.Rs = rs;
    bus.Rt = rt;
    bus.Rd = rd;
    bus.SignExtImm = imm;
    bus.ReadData1  = 16'($urandom);
    bus.ReadData2  = 16'($urandom);
    bus.PCPlus     = 16'($urandom);
  endtask

  function automatic logic model_stall();
    logic rs_use, rt_use;
    rs_use = bus.OpCode inside {3'd0, 3'd2, 3'd3, 3'd5, 3'd6};
    rt_use = bus.OpCode inside {3'd0, 3'd2, 3'd6};
    return m.valid && m.ctrl[3] && ((rs_use && bus.Rs == m.rt) || (rt_use && bus.Rt == m.rt))
           && !bus.Flush && !bus.Hold;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    e = q.pop_front();
    chk({tag, " ctrl"}, {7'd0, bus.ex_RegWrite, bus.ex_RegDst, bus.ex_ALUSrc, bus.ex_Branch,
                         bus.ex_MemWrite, bus.ex_MemRead, bus.ex_MemtoReg, bus.ex_ALUOp},
        {7'd0, e.ctrl});
    chk({tag, " valid"}, {15'd0, bus.ex_Valid}, {15'd0, e.valid});
    chk({tag, " bcnt"}, bus.BubbleCount, e.bcnt);
    if (e.dk) begin
      chk({tag, " rd1"}, bus.ex_ReadData1, e.rd1);
      chk({tag, " rd2"}, bus.ex_ReadData2, e.rd2);
      chk({tag, " imm"}, bus.ex_SignExtImm, e.imm);
      chk({tag, " pc"}, bus.ex_PCPlus, e.pc);
      chk({tag, " regs"}, {7'd0, bus.ex_Rs, bus.ex_Rt, bus.ex_Rd}, {7'd0, e.rs, e.rt, e.rd});
    end
  endtask

  // Called just after a falling edge with ID inputs already driven
  task automatic step(input string tag);
    logic s;
    #1;
    s = model_stall();
    chk({tag, " Stall"}, {15'd0, bus.Stall}, {15'd0, s});
    if (bus.Flush) begin
      m.ctrl = 9'd0; m.valid = 1'b0; m.dk = 1'b0;
    end else if (!bus.Hold) begin
      if (s) begin
        m.ctrl = 9'd0; m.valid = 1'b0; m.dk = 1'b0;
        if (m.bcnt != 16'hFFFF) m.bcnt = m.bcnt + 16'd1;
      end else begin
        m.ctrl = {bus.RegWrite, bus.RegDst, bus.ALUSrc, bus.Branch,
                  bus.MemWrite, bus.MemRead, bus.MemtoReg, bus.ALUOp};
        m.rd1 = bus.ReadData1; m.rd2 = bus.ReadData2;
        m.imm = bus.SignExtImm; m.pc = bus.PCPlus;
        m.rs = bus.Rs; m.rt = bus.Rt; m.rd = bus.Rd;
        m.valid = 1'b1; m.dk = 1'b1;
      end
    end
    q.push_back(m);
    @(posedge clock);
    #1;
    compare_out(tag);
    @(negedge clock);
  endtask

  // Pulses reset without a clock edge; the caller's next step() exercises the first edge
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    m = '0;
    m.dk = 1'b1;
    q.push_back(m);
    compare_out(tag);
    chk({tag, " Stall"}, {15'd0, bus.Stall}, 16'd0);
    #1;
    reset = 1'b0;
  endtask

  task automatic hazard(input string tag);
    set_id(3'd5, C_LOAD, 3'd1, 3'd2, 3'd0, 16'h0010);
    step({tag, " load"});
    set_id(3'd0, C_RTYPE, 3'd2, 3'd4, 3'd5, 16'h0000);
    step({tag, " use"});
  endtask

  initial begin
    bus.Flush = 1'b0;
    bus.Hold  = 1'b0;
    set_id(3'd7, 9'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
    m = '0;
    #1;
    do_reset("reset");

    set_id(3'd3, C_ADDI, 3'd1, 3'd2, 3'd3, 16'h0005);
    step("addi");
    chk("addi RegWrite", {15'd0, bus.ex_RegWrite}, 16'd1);
    chk("addi ALUSrc", {15'd0, bus.ex_ALUSrc}, 16'd1);
    chk("addi ALUOp", {14'd0, bus.ex_ALUOp}, 16'd0);
    chk("addi imm", bus.ex_SignExtImm, 16'h0005);
    chk("addi valid", {15'd0, bus.ex_Valid}, 16'd1);

    hazard("rs_use");
    chk("bubble valid", {15'd0, bus.ex_Valid}, 16'd0);
    chk("bubble MemRead", {15'd0, bus.ex_MemRead}, 16'd0);
    chk("bubble count", bus.BubbleCount, 16'd1);
    #1;
    chk("stall released", {15'd0, bus.Stall}, 16'd0);
    step("after bubble");
    chk("dependent loaded", {15'd0, bus.ex_Valid}, 16'd1);

    set_id(3'd5, C_LOAD, 3'd1, 3'd2, 3'd0, 16'h0020);
    step("load2");
    set_id(3'd3, C_ADDI, 3'd3, 3'd2, 3'd0, 16'h0007);
    #1;
    chk("addi rt no stall", {15'd0, bus.Stall}, 16'd0);
    step("addi rt");

    set_id(3'd5, C_LOAD, 3'd1, 3'd2, 3'd0, 16'h0030);
    step("load3");
    set_id(3'd0, C_RTYPE, 3'd2, 3'd4, 3'd5, 16'h0000);
    bus.Flush = 1'b1;
    step("flush");
    bus.Flush = 1'b0;
    chk("flush valid", {15'd0, bus.ex_Valid}, 16'd0);
    chk("flush bcnt", bus.BubbleCount, 16'd1);

    set_id(3'd5, C_LOAD, 3'd1, 3'd2, 3'd0, 16'h0040);
    step("load4");
    set_id(3'd2, C_RTYPE, 3'd6, 3'd2, 3'd1, 16'h0000);
    step("rt_use");
    set_id(3'd5, C_LOAD, 3'd1, 3'd0, 3'd0, 16'h0050);
    step("load r0");
    set_id(3'd6, C_BR, 3'd0, 3'd7, 3'd0, 16'h0008);
    step("r0 use");
    chk("r0 bcnt", bus.BubbleCount, 16'd3);
    step("r0 after");

    set_id(3'd3, C_ADDI, 3'd4, 3'd5, 3'd6, 16'h0042);
    step("hold base");
    for (int i = 0; i < 3; i++) begin
      set_id(3'($urandom_range(0, 7)), 9'($urandom), 3'($urandom), 3'($urandom),
             3'($urandom), 16'($urandom));
      bus.Hold = 1'b1;
      step("hold");
      chk("hold imm", bus.ex_SignExtImm, 16'h0042);
    end
    bus.Hold = 1'b0;
    set_id(3'd0, C_RTYPE, 3'd1, 3'd3, 3'd7, 16'h0099);
    step("hold release");

    set_id(3'd5, C_LOAD, 3'd1, 3'd2, 3'd0, 16'h0060);
    step("load5");
    set_id(3'd0, C_RTYPE, 3'd2, 3'd4, 3'd5, 16'h0000);
    #1;
    chk("pre-reset stall", {15'd0, bus.Stall}, 16'd1);
    do_reset("reset mid-stall");
    step("load after reset");

    bus.Hold = 1'b1;
    step("hold pre-reset");
    do_reset("reset mid-hold");
    bus.Hold = 1'b0;
    step("load after hold reset");

    force dut.r_bcnt = 16'hFFFD;
    #1;
    release dut.r_bcnt;
    m.bcnt = 16'hFFFD;
    @(negedge clock);
    for (int i = 0; i < 3; i++) hazard("sat");
    chk("saturated", bus.BubbleCount, 16'hFFFF);
    #1;
    do_reset("reset sat");
    chk("sat cleared", bus.BubbleCount, 16'h0000);
    step("final load");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 16, datapath width (register data, immediate, PC).
REQ-002 Parameter REG_W, default 3, register-address width.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 OpCode  input  3  opcode of the instruction in ID, from the IF/ID register.
REQ-006 RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemRead, MemtoReg  input  1 each  ID control from the decoder.
REQ-007 ALUOp  input  2  ID ALU operation class from the decoder.
REQ-008 ReadData1, ReadData2  input  DATA_W  register-file read data for Rs and Rt.
REQ-009 SignExtImm  input  DATA_W  sign-extended immediate.
REQ-010 PCPlus  input  DATA_W  address of the next sequential instruction.
REQ-011 Rs, Rt, Rd  input  REG_W each  ID register fields.
REQ-012 Flush  input  1  branch taken in EX; squash the ID instruction.
REQ-013 Hold  input  1  downstream not ready; freeze the stage.
REQ-014 ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_Branch, ex_MemWrite, ex_MemRead, ex_MemtoReg  output  1 each  registered control for EX.
REQ-015 ex_ALUOp  output  2  registered ALUOp.
REQ-016 ex_ReadData1, ex_ReadData2, ex_SignExtImm, ex_PCPlus  output  DATA_W each  registered datapath values.
REQ-017 ex_Rs, ex_Rt, ex_Rd  output  REG_W each  registered register fields.
REQ-018 ex_Valid  output  1  EX holds a real (non-bubble) instruction.
REQ-019 Stall  output  1  combinational load-use stall request to PC and IF/ID (hold them).
REQ-020 BubbleCount  output  16  saturating count of bubbles inserted for load-use.

Function
REQ-021 Rs-use SHALL be true for OpCode 0, 2, 3, 5, 6; Rt-use SHALL be true for OpCode 0, 2, 6; other opcodes use neither.
REQ-022 Stall SHALL be 1 iff ex_Valid & ex_MemRead & ((Rs-use & Rs==ex_Rt) | (Rt-use & Rt==ex_Rt)) & ~Flush & ~Hold.
REQ-023 Each rising edge SHALL apply exactly one action, priority Flush > Hold > Stall > Load.
REQ-024 Flush: all ex_ control outputs and ex_Valid SHALL become 0; datapath outputs SHALL take don't-care values (implementation loads them).
REQ-025 Hold: every ex_ output, ex_Valid and BubbleCount SHALL keep its value.
REQ-026 Stall: control outputs and ex_Valid SHALL become 0 (bubble); BubbleCount SHALL increment by 1, saturating at 0xFFFF.
REQ-027 Load: all ex_ outputs SHALL capture their ID inputs next edge; ex_Valid SHALL become 1.
REQ-028 Latency SHALL be one cycle ID to EX; a load followed by a dependent instruction SHALL cost exactly one bubble cycle.
REQ-029 Stall SHALL deassert the cycle after the bubble enters EX (ex_Valid=0 breaks the condition) without extra state.
REQ-030 Register compares SHALL apply to register 0 like any other register (no r0 exemption).
REQ-031 Flush and Stall in the same cycle: Flush wins; BubbleCount SHALL NOT increment.

Reset
REQ-032 On reset all ex_ outputs, ex_Valid and BubbleCount SHALL be 0; Stall SHALL therefore be 0.
REQ-033 Reset asserted mid-Hold or mid-Stall SHALL clear state immediately; first edge after release SHALL perform Load.

Verification
REQ-034 Reset release, OpCode=3 addi Rs=1 Rt=2, SignExtImm=0x0005 -> next edge ex_RegWrite=1, ex_ALUSrc=1, ex_ALUOp=0, ex_SignExtImm=0x0005, ex_Valid=1.
REQ-035 EX holds load (OpCode 5, ex_Rt=2); ID R-type Rs=2 -> Stall=1, next edge ex_Valid=0, all ex_ control 0, BubbleCount=1; following cycle Stall=0.
REQ-036 EX holds load ex_Rt=2; ID addi Rt=2 Rs=3 -> Stall=0 (Rt not a source for opcode 3).
REQ-037 Flush=1 with a load-use hazard present -> next edge ex_Valid=0, controls 0, Stall=0, BubbleCount unchanged.
REQ-038 Hold=1 for 3 cycles with changing ID inputs -> all ex_ outputs constant; Hold=0 -> next edge loads current ID values.
REQ-039 BubbleCount preloaded to 0xFFFF by 65535 hazards, one more hazard -> BubbleCount stays 0xFFFF; reset -> 0.
